// File: rtl/framebuffer_pixel_sink_if.sv
// Pixel-stream, clear and read-out signals between rasterizer/display side and the framebuffer sink.
// master drives beats, clear and reads; slave is the sink.
interface framebuffer_pixel_sink_if;
   logic [7:0]  px;
   logic [7:0]  py;
   logic [23:0] pixel_color;
   logic        pixel_valid;
   logic        done;
   logic        clear_req;
   logic [23:0] clear_color;
   logic        rd_en;
   logic [7:0]  rd_x;
   logic [7:0]  rd_y;
   logic        rd_valid;
   logic [23:0] rd_data;
   logic        busy_clear;
   logic        overflow;
   logic        frame_complete;
   logic [15:0] pix_count;

   modport master (
      output px, py, pixel_color, pixel_valid, done, clear_req, clear_color, rd_en, rd_x, rd_y,
      input  rd_valid, rd_data, busy_clear, overflow, frame_complete, pix_count
   );

   modport slave (
      input  px, py, pixel_color, pixel_valid, done, clear_req, clear_color, rd_en, rd_x, rd_y,
      output rd_valid, rd_data, busy_clear, overflow, frame_complete, pix_count
   );
endinterface

// File: rtl/framebuffer_pixel_sink.sv
// Pixel sink: clipped beats -> FIFO -> single-port framebuffer RAM, plus clear engine and 1-cycle read port.
// No input back-pressure: a beat arriving at a full FIFO with no pop is dropped and flagged in overflow.
module framebuffer_pixel_sink #(
   parameter int FB_W       = 64,
   parameter int FB_H       = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   framebuffer_pixel_sink_if.slave bus
);
   localparam int XW    = $clog2(FB_W);
   localparam int YW    = $clog2(FB_H);
   localparam int AW    = XW + YW;
   localparam int DEPTH = FB_W * FB_H;
   localparam int PW    = $clog2(FIFO_DEPTH);

   typedef enum logic {RUN, CLEAR} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [23:0]   color;
   } beat_t;

   state_t        state;
   logic [AW-1:0] clr_addr;
   logic [23:0]   clr_color;
   logic          done_pending;

   beat_t         fifo_mem [FIFO_DEPTH];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [23:0]   ram [DEPTH];

   logic          fifo_empty;
   logic          fifo_full;
   logic          in_range;
   logic          accept;
   logic          pop;
   logic          push;
   logic          drop;
   logic          clr_wr;
   logic          fc_fire;
   beat_t         head;
   beat_t         in_beat;
   logic [AW-1:0] rd_addr;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [23:0]   ram_wdata;

   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = ((wr_ptr - rd_ptr) == (PW+1)'(FIFO_DEPTH));
      in_range   = ({1'b0, bus.px} < 9'(FB_W)) && ({1'b0, bus.py} < 9'(FB_H));
      accept     = bus.pixel_valid && in_range;
      // Reads own the RAM port; pops also wait out a clear, including its request cycle.
      pop        = !fifo_empty && (state == RUN) && !bus.rd_en && !bus.clear_req;
      push       = accept && (!fifo_full || pop);
      drop       = accept && fifo_full && !pop;
      clr_wr     = (state == CLEAR) && !bus.rd_en && !bus.clear_req;
      fc_fire    = done_pending && (state == RUN) && fifo_empty && !pop;
      head       = fifo_mem[rd_ptr[PW-1:0]];
      in_beat    = '{addr: {bus.py[YW-1:0], bus.px[XW-1:0]}, color: bus.pixel_color};
      rd_addr    = {bus.rd_y[YW-1:0], bus.rd_x[XW-1:0]};
      ram_we     = clr_wr || pop;
      ram_waddr  = clr_wr ? clr_addr  : head.addr;
      ram_wdata  = clr_wr ? clr_color : head.color;
   end

   // Storage arrays carry no reset; their contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr[PW-1:0]] <= in_beat;
      if (ram_we)
         ram[ram_waddr] <= ram_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RUN;
         busy_clear_rst();
         clr_addr       <= '0;
         clr_color      <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         done_pending   <= 1'b0;
         bus.overflow   <= 1'b0;
         bus.pix_count  <= '0;
         bus.frame_complete <= 1'b0;
         bus.rd_valid   <= 1'b0;
         bus.rd_data    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en)
            bus.rd_data <= ram[rd_addr];

         if (bus.clear_req) begin
            state          <= CLEAR;
            bus.busy_clear <= 1'b1;
            clr_addr       <= '0;
            clr_color      <= bus.clear_color;
         end else if (clr_wr) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == AW'(DEPTH - 1)) begin
               state          <= RUN;
               bus.busy_clear <= 1'b0;
            end
         end

         if (bus.clear_req)
            bus.overflow <= 1'b0;
         if (drop)
            bus.overflow <= 1'b1;

         if (bus.clear_req)
            bus.pix_count <= '0;
         else if (pop && (bus.pix_count != 16'hFFFF))
            bus.pix_count <= bus.pix_count + 16'd1;

         // A done seen while one is already pending folds into the same event.
         bus.frame_complete <= fc_fire;
         done_pending       <= fc_fire ? 1'b0 : (done_pending || bus.done);
      end
   end

   task automatic busy_clear_rst();
      bus.busy_clear <= 1'b0;
   endtask
endmodule

// File: tb/tb_framebuffer_pixel_sink.sv
// Directed + randomized bench for framebuffer_pixel_sink against a whole-frame reference image.
module tb_framebuffer_pixel_sink;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   framebuffer_pixel_sink_if bus();

   framebuffer_pixel_sink #(.FB_W(64), .FB_H(64), .FIFO_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [23:0] fb [4096];
   int          exp_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic fill_model(input logic [23:0] c);
      for (int i = 0; i < 4096; i++) fb[i] = c;
   endtask

   task automatic rd_check(input int x, input int y, input string tag);
      bus.rd_en = 1'b1;
      bus.rd_x  = 8'(x);
      bus.rd_y  = 8'(y);
      tick();
      bus.rd_en = 1'b0;
      chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
      chk(tag, 32'(bus.rd_data), 32'(fb[(y % 64) * 64 + (x % 64)]));
   endtask

   task automatic start_clear(input logic [23:0] c);
      bus.clear_req   = 1'b1;
      bus.clear_color = c;
      tick();
      bus.clear_req   = 1'b0;
      fill_model(c);
      exp_count = 0;
   endtask

   task automatic wait_clear(input string tag);
      int n = 0;
      while (bus.busy_clear !== 1'b0 && n < 6000) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.busy_clear), 32'd0);
   endtask

   initial begin
      int          n;
      int          first;
      int          pulses;
      int          x;
      int          y;
      logic [23:0] c;
      logic [23:0] cols [10];
      int          wq [$];

      bus.px = '0; bus.py = '0; bus.pixel_color = '0; bus.pixel_valid = 1'b0;
      bus.done = 1'b0; bus.clear_req = 1'b0; bus.clear_color = '0;
      bus.rd_en = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
      exp_count = 0;

      // Reset state
      tick(2);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_busy", 32'(bus.busy_clear), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_fc", 32'(bus.frame_complete), 0);
      chk("rst_pix_count", 32'(bus.pix_count), 0);
      rst = 1'b0;
      tick();

      // Basic write then read at the earliest legal edge
      bus.px = 8'd3; bus.py = 8'd5; bus.pixel_color = 24'h112233; bus.pixel_valid = 1'b1;
      tick();
      bus.pixel_valid = 1'b0;
      tick();
      fb[5 * 64 + 3] = 24'h112233;
      rd_check(3, 5, "basic_rd");
      chk("basic_pix_count", 32'(bus.pix_count), 1);
      tick();
      chk("no_read_rd_valid", 32'(bus.rd_valid), 0);

      // Clear: busy length and contents
      start_clear(24'h0000FF);
      n = 0;
      while (bus.busy_clear === 1'b1 && n < 6000) begin
         n++;
         tick();
      end
      chk("clear_len", 32'(n), 32'd4096);
      rd_check(0, 0, "clear_rd00");
      rd_check(63, 63, "clear_rd6363");
      rd_check(17, 40, "clear_rd1740");
      chk("clear_pix_count", 32'(bus.pix_count), 0);

      // Clipping
      bus.px = 8'd64; bus.py = 8'd0; bus.pixel_color = 24'hDEAD01; bus.pixel_valid = 1'b1;
      tick();
      bus.px = 8'd0; bus.py = 8'd200; bus.pixel_color = 24'hDEAD02;
      tick();
      bus.pixel_valid = 1'b0;
      tick(3);
      chk("clip_pix_count", 32'(bus.pix_count), 0);
      chk("clip_overflow", 32'(bus.overflow), 0);
      rd_check(0, 0, "clip_rd00");
      rd_check(0, 8, "clip_rd08");

      // Overflow: 10 beats during a clear, FIFO holds 8
      start_clear(24'hABCDEF);
      for (int i = 0; i < 10; i++) begin
         cols[i] = 24'($urandom);
         bus.px = 8'(i); bus.py = 8'd1; bus.pixel_color = cols[i]; bus.pixel_valid = 1'b1;
         tick();
      end
      bus.pixel_valid = 1'b0;
      chk("ovf_flag", 32'(bus.overflow), 1);
      chk("ovf_busy", 32'(bus.busy_clear), 1);
      wait_clear("ovf_clear_end");
      tick(10);
      for (int i = 0; i < 8; i++) fb[64 + i] = cols[i];
      exp_count = 8;
      chk("ovf_pix_count", 32'(bus.pix_count), 32'(exp_count));
      for (int i = 0; i < 10; i++) rd_check(i, 1, "ovf_rd");

      // Read priority: 20 back-to-back reads starve the writes
      for (int i = 0; i < 20; i++) begin
         bus.rd_en = 1'b1; bus.rd_x = 8'd20; bus.rd_y = 8'd2;
         bus.pixel_valid = (i < 3);
         bus.px = 8'(30 + i); bus.py = 8'd3; bus.pixel_color = 24'h300000 + 24'(i);
         tick();
         chk("prio_rd_valid", 32'(bus.rd_valid), 1);
         chk("prio_rd_data", 32'(bus.rd_data), 32'(fb[2 * 64 + 20]));
         chk("prio_pix_count", 32'(bus.pix_count), 32'(exp_count));
      end
      bus.rd_en = 1'b0; bus.pixel_valid = 1'b0;
      for (int i = 0; i < 3; i++) fb[3 * 64 + 30 + i] = 24'h300000 + 24'(i);
      exp_count += 3;
      tick();
      chk("prio_rd_valid_off", 32'(bus.rd_valid), 0);
      tick(2);
      chk("prio_pix_count_after", 32'(bus.pix_count), 32'(exp_count));
      chk("prio_overflow_sticky", 32'(bus.overflow), 1);
      for (int i = 0; i < 3; i++) rd_check(30 + i, 3, "prio_rd_back");

      // Randomized stream against the reference image
      start_clear(24'($urandom));
      wait_clear("rand_clear_end");
      for (int i = 0; i < 300; i++) begin
         x = $urandom_range(0, 79);
         y = $urandom_range(0, 71);
         c = 24'($urandom);
         bus.px = 8'(x); bus.py = 8'(y); bus.pixel_color = c;
         bus.pixel_valid = ($urandom_range(0, 1) == 1);
         if (bus.pixel_valid && x < 64 && y < 64) begin
            fb[y * 64 + x] = c;
            exp_count++;
            wq.push_back(y * 64 + x);
         end
         tick();
      end
      bus.pixel_valid = 1'b0;
      tick(12);
      chk("rand_pix_count", 32'(bus.pix_count), 32'(exp_count));
      chk("rand_overflow", 32'(bus.overflow), 0);
      for (int i = 0; i < 20 && i < wq.size(); i++) rd_check(wq[i] % 64, wq[i] / 64, "rand_rd_written");
      for (int i = 0; i < 10; i++) rd_check($urandom_range(0, 255), $urandom_range(0, 255), "rand_rd_any");

      // frame_complete after 4 beats, done on the cycle after the last beat
      for (int i = 0; i < 4; i++) begin
         bus.px = 8'(40 + i); bus.py = 8'd50; bus.pixel_color = 24'h500000 + 24'(i);
         bus.pixel_valid = 1'b1;
         tick();
      end
      bus.pixel_valid = 1'b0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      chk("fc_early", 32'(bus.frame_complete), 0);
      pulses = 0;
      first  = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.frame_complete === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      chk("fc_pulses", 32'(pulses), 1);
      chk("fc_cycle", 32'(first), 0);
      exp_count += 4;
      chk("fc_pix_count", 32'(bus.pix_count), 32'(exp_count));

      // Asynchronous reset in the middle of a clear
      start_clear(24'h777777);
      for (int i = 0; i < 10; i++) begin
         bus.px = 8'(i); bus.py = 8'd9; bus.pixel_color = 24'h123456; bus.pixel_valid = 1'b1;
         tick();
      end
      bus.pixel_valid = 1'b0;
      bus.rd_en = 1'b1; bus.rd_x = 8'd3; bus.rd_y = 8'd5;
      tick();
      bus.rd_en = 1'b0;
      chk("mid_busy", 32'(bus.busy_clear), 1);
      chk("mid_overflow", 32'(bus.overflow), 1);
      chk("mid_rd_valid", 32'(bus.rd_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_rd_valid", 32'(bus.rd_valid), 0);
      chk("arst_rd_data", 32'(bus.rd_data), 0);
      chk("arst_busy", 32'(bus.busy_clear), 0);
      chk("arst_overflow", 32'(bus.overflow), 0);
      chk("arst_fc", 32'(bus.frame_complete), 0);
      chk("arst_pix_count", 32'(bus.pix_count), 0);
      tick(2);
      rst = 1'b0;
      tick(3);
      chk("post_rst_busy", 32'(bus.busy_clear), 0);
      chk("post_rst_pix_count", 32'(bus.pix_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
